univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised universal shift register, the general-purpose successor to our fixed 4-bit serial-in shift register. It supports hold, bidirectional shift, rotate and parallel load. A shift counter flags each completed WIDTH-bit frame, so the block works as a SIPO deserialiser, a PISO serialiser or a barrel-style rotator. It sits between serial links and word-wide datapaths in the ACA lab designs.

## Interface
- WIDTH, 8, register width in bits; WIDTH >= 2
- CW, $clog2(WIDTH), shift-counter width (derived, do not override)

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- en  in  1  clock enable; when low, all state holds
- mode  in  3  operation select (encoding below)
- si_l  in  1  serial input entering at MSB on shift right
- si_r  in  1  serial input entering at LSB on shift left
- pdata  in  WIDTH  parallel load data
- q  out  WIDTH  register contents (registered)
- so_l  out  1  q[WIDTH-1], serial out for left shift (combinational from q)
- so_r  out  1  q[0], serial out for right shift (combinational from q)
- shift_cnt  out  CW  shifts/rotates completed in the current frame, 0..WIDTH-1
- frame_done  out  1  one-cycle pulse marking WIDTH shifts since the last load or reset

## Operation
- Priority per edge: rst=0, then en=0, then mode.
- Reset (rst=0): q=0, shift_cnt=0, frame_done=0, regardless of en or mode.
- en=0: q and shift_cnt hold; frame_done=0.
- Mode 000, hold: q and shift_cnt hold; frame_done=0.
- Mode 001, shift left: q <= {q[WIDTH-2:0], si_r}.
- Mode 010, shift right: q <= {si_l, q[WIDTH-1:1]}.
- Mode 011, parallel load: q <= pdata; shift_cnt <= 0; frame_done <= 0.
- Mode 100, rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- Mode 101, rotate right: q <= {q[0], q[WIDTH-1:1]}.
- Modes 110 and 111: reserved; behave exactly as hold.
- Counter: every edge executing modes 001, 010, 100 or 101 is a "shift op".
  - If shift_cnt < WIDTH-1: shift_cnt increments and frame_done <= 0.
  - If shift_cnt == WIDTH-1: shift_cnt wraps to 0 and frame_done <= 1.
- Direction changes mid-frame do not clear the counter; shift and rotate ops count alike.
- frame_done is high for exactly one cycle per frame. Back-to-back frames give a pulse every WIDTH cycles with no gap cycles.

## Timing
- Latency: q, shift_cnt and frame_done all change on the same rising edge that samples en, mode and data. There is no pipeline.
- frame_done rises on the edge of the WIDTH-th shift op and so coincides with q holding the complete frame. It falls on the next edge unless that edge is the WIDTH-th op of another frame, which is possible only when WIDTH=1 and is therefore excluded.
- so_l and so_r follow q with zero added latency.
- Reset mid-frame discards partial data. The next frame needs a full WIDTH shift ops.
- A load on the same cycle the counter would wrap takes precedence: the load is performed and frame_done stays 0.

## Test plan
- Reset override: rst=0, en=1, mode=011, pdata=8'hFF for one edge -> q=8'h00, shift_cnt=0, frame_done=0.
- SIPO frame: after reset, mode=001 for 8 edges with si_r = 1,0,1,1,0,0,1,0 -> q=8'hB2 after the 8th edge; frame_done=1 for that cycle only; shift_cnt=0.
- Rotate: load 8'h81; rotate right once -> 8'hC0; rotate left twice -> 8'h81 then 8'h03; shift_cnt=3; frame_done never asserts.
- Enable gating and reserved modes: load 8'h00; mode=010, si_l=1, en=1 for 3 edges with one en=0 edge inserted -> q=8'hE0, shift_cnt=3. A following mode=110 edge holds q=8'hE0.
- Reset mid-frame: 5 shift-left ops, then rst=0 for one edge -> q=0, shift_cnt=0. frame_done next asserts on the 8th subsequent shift op, not the 3rd.
- Load at wrap: 7 shift ops, then load 8'h5A -> q=8'h5A, shift_cnt=0, frame_done=0. Back-to-back 16 shift ops then give frame_done pulses exactly on ops 8 and 16.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left/right, rotate left/right and parallel load,
// with a shift counter that pulses frame_done on every completed WIDTH-bit frame.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             si_l,
    input  logic             si_r,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             so_l,
    output logic             so_r,
    output logic [CW-1:0]    shift_cnt,
    output logic             frame_done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             shift_op;

    always_comb begin
        q_d      = q_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        shift_op = 1'b0;
        if (en) begin
            case (mode)
                MODE_SHL: begin
                    q_d      = {q_q[WIDTH-2:0], si_r};
                    shift_op = 1'b1;
                end
                MODE_SHR: begin
                    q_d      = {si_l, q_q[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                MODE_LOAD: begin
                    q_d   = pdata;
                    cnt_d = '0;
                end
                MODE_ROL: begin
                    q_d      = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                    shift_op = 1'b1;
                end
                MODE_ROR: begin
                    q_d      = {q_q[0], q_q[WIDTH-1:1]};
                    shift_op = 1'b1;
                end
                // MODE_HOLD and the reserved encodings keep the defaults
                default: begin
                    q_d = q_q;
                end
            endcase
        end
        // Direction does not matter to the counter; any shift or rotate advances the frame
        if (shift_op) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q          = q_q;
    assign so_l       = q_q[WIDTH-1];
    assign so_r       = q_q[0];
    assign shift_cnt  = cnt_q;
    assign frame_done = done_q;

    // MODE_HOLD is documented here for readers; it needs no explicit case arm
    logic unused_hold_marker;
    assign unused_hold_marker = (MODE_HOLD == 3'b000);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic          si_l = 1'b0;
    logic          si_r = 1'b0;
    logic [W-1:0]  pdata = '0;
    logic [W-1:0]  q;
    logic          so_l, so_r;
    logic [CW-1:0] shift_cnt;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model: register value as an integer, op count since last load/reset
    int m_q   = 0;
    int m_ops = 0;
    int m_fd  = 0;
    bit chk_en = 1'b0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .si_l(si_l), .si_r(si_r),
        .pdata(pdata), .q(q), .so_l(so_l), .so_r(so_r),
        .shift_cnt(shift_cnt), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One transaction: drive on the falling edge, advance the model at the rising edge
    task automatic step(input bit r, input bit e, input logic [2:0] md,
                        input bit sl, input bit sr, input logic [W-1:0] pd);
        bit op;
        @(negedge clk);
        rst = r; en = e; mode = md; si_l = sl; si_r = sr; pdata = pd;
        @(posedge clk);
        op = 1'b0;
        if (!r) begin
            m_q = 0; m_ops = 0; m_fd = 0;
        end else if (!e) begin
            m_fd = 0;
        end else begin
            case (md)
                3'd1: begin m_q = (m_q * 2 + int'(sr)) % (1 << W); op = 1'b1; end
                3'd2: begin m_q = m_q / 2 + int'(sl) * (1 << (W - 1)); op = 1'b1; end
                3'd3: begin m_q = int'(pd); m_ops = 0; m_fd = 0; end
                3'd4: begin m_q = (m_q * 2) % (1 << W) + m_q / (1 << (W - 1)); op = 1'b1; end
                3'd5: begin m_q = m_q / 2 + (m_q % 2) * (1 << (W - 1)); op = 1'b1; end
                default: m_fd = 0;
            endcase
            if (op) begin
                m_ops++;
                m_fd = (m_ops % W == 0) ? 1 : 0;
            end
        end
        #1;
        $display("txn t=%0t rst=%0b en=%0b mode=%0d si_l=%0b si_r=%0b pdata=%02h -> q=%02h cnt=%0d fd=%0b",
                 $time, r, e, md, sl, sr, pd, q, shift_cnt, frame_done);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_q", 32'(q), 32'(m_q));
            check("model_so_l", 32'(so_l), 32'(m_q / (1 << (W - 1))));
            check("model_so_r", 32'(so_r), 32'(m_q % 2));
            check("model_cnt", 32'(shift_cnt), 32'(m_ops % W));
            check("model_fd", 32'(frame_done), 32'(m_fd));
        end
    end

    initial begin
        logic [7:0] sipo_bits;
        sipo_bits = 8'b1011_0010;

        // Reset overrides an enabled load
        step(0, 1, 3'b011, 0, 0, 8'hFF);
        chk_en = 1'b1;
        check("rst_q", 32'(q), 32'h00);
        check("rst_cnt", 32'(shift_cnt), 32'd0);
        check("rst_fd", 32'(frame_done), 32'd0);

        // SIPO frame, first bit ends up at the MSB
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 3'b001, 0, sipo_bits[7 - i], 8'h00);
            check("sipo_fd", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
        end
        check("sipo_q", 32'(q), 32'hB2);
        check("sipo_cnt", 32'(shift_cnt), 32'd0);
        step(1, 1, 3'b000, 0, 0, 8'h00);
        check("sipo_fd_fall", 32'(frame_done), 32'd0);

        // Rotations
        step(1, 1, 3'b011, 0, 0, 8'h81);
        check("load_81", 32'(q), 32'h81);
        step(1, 1, 3'b101, 0, 0, 8'h00);
        check("ror_q", 32'(q), 32'hC0);
        step(1, 1, 3'b100, 0, 0, 8'h00);
        check("rol1_q", 32'(q), 32'h81);
        check("rot_fd", 32'(frame_done), 32'd0);
        step(1, 1, 3'b100, 0, 0, 8'h00);
        check("rol2_q", 32'(q), 32'h03);
        check("rot_cnt", 32'(shift_cnt), 32'd3);
        check("rot_fd2", 32'(frame_done), 32'd0);

        // Enable gating and reserved modes
        step(1, 1, 3'b011, 0, 0, 8'h00);
        step(1, 1, 3'b010, 1, 0, 8'h00);
        step(1, 1, 3'b010, 1, 0, 8'h00);
        step(1, 0, 3'b010, 1, 0, 8'h00);
        check("en_gate_q", 32'(q), 32'hC0);
        check("en_gate_cnt", 32'(shift_cnt), 32'd2);
        step(1, 1, 3'b010, 1, 0, 8'h00);
        check("shr_q", 32'(q), 32'hE0);
        check("shr_cnt", 32'(shift_cnt), 32'd3);
        step(1, 1, 3'b110, 1, 1, 8'hFF);
        check("rsv6_q", 32'(q), 32'hE0);
        check("rsv6_cnt", 32'(shift_cnt), 32'd3);
        step(1, 1, 3'b111, 1, 1, 8'hFF);
        check("rsv7_q", 32'(q), 32'hE0);

        // Reset mid-frame discards partial progress
        for (int i = 0; i < 5; i++) step(1, 1, 3'b001, 0, 1, 8'h00);
        step(0, 1, 3'b001, 0, 1, 8'h00);
        check("midrst_q", 32'(q), 32'h00);
        check("midrst_cnt", 32'(shift_cnt), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 3'b001, 0, 1, 8'h00);
            check("midrst_fd", 32'(frame_done), (i == 7) ? 32'd1 : 32'd0);
        end
        check("midrst_q_full", 32'(q), 32'hFF);

        // Load at the wrap point wins over the frame pulse
        for (int i = 0; i < 7; i++) step(1, 1, 3'b001, 0, 0, 8'h00);
        check("prewrap_cnt", 32'(shift_cnt), 32'd7);
        step(1, 1, 3'b011, 0, 0, 8'h5A);
        check("wrapload_q", 32'(q), 32'h5A);
        check("wrapload_cnt", 32'(shift_cnt), 32'd0);
        check("wrapload_fd", 32'(frame_done), 32'd0);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, (i % 2 == 0) ? 3'b100 : 3'b101, 0, 0, 8'h00);
            check("b2b_fd", 32'(frame_done), (i == 7 || i == 15) ? 32'd1 : 32'd0);
        end
        check("b2b_q", 32'(q), 32'h5A);

        // Mixed sequence checked only against the model
        for (int i = 0; i < 24; i++)
            step(1, (i % 5) != 3, 3'(i % 8), i[0], i[1], 8'(i * 37));

        @(negedge clk);
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
